// File: rtl/rx_pixel_loader.sv
// Loads one grayscale frame from a serial byte stream into image memory.
// The load starts after a sync byte, aborts on an inter-byte timeout, and holds the frame until the pipeline releases it.
module rx_pixel_loader #(
  parameter int unsigned IMG_W       = 160,
  parameter int unsigned IMG_H       = 120,
  parameter int unsigned ADDR_W      = 15,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  input  logic              libera,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata,
  output logic              frame_ready,
  output logic              carregando,
  output logic              erro_timeout,
  output logic [1:0]        db_estado
);

  localparam int unsigned PIX_N   = IMG_W * IMG_H;
  localparam int unsigned TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit          ADDR_OK = ((64'd1 << ADDR_W) >= 64'(PIX_N));

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    READY = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                frame_ready_q, frame_ready_d;
  logic                carregando_q, carregando_d;
  logic                err_q, err_d;
  logic [1:0]          db_estado_q, db_estado_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) begin
          state_d = LOAD;
          count_d = '0;
          timer_d = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        // An arriving byte takes priority over an expiring timer
        if (byte_valid) begin
          we_d    = 1'b1;
          addr_d  = count_q;
          wdata_d = byte_in;
          timer_d = '0;
          if (count_q == ADDR_W'(PIX_N - 1)) begin
            state_d = READY;
            count_d = '0;
          end else begin
            count_d = count_q + ADDR_W'(1);
          end
        end else if (timer_q == TIMER_W'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
          count_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      READY: begin
        if (libera) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    frame_ready_d = (state_d == READY);
    carregando_d  = (state_d == LOAD);
    db_estado_d   = state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      timer_q       <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      frame_ready_q <= 1'b0;
      carregando_q  <= 1'b0;
      err_q         <= 1'b0;
      db_estado_q   <= 2'b00;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      frame_ready_q <= frame_ready_d;
      carregando_q  <= carregando_d;
      err_q         <= err_d;
      db_estado_q   <= db_estado_d;
    end
  end

  assign we           = we_q;
  assign addr         = addr_q;
  assign wdata        = wdata_q;
  assign frame_ready  = frame_ready_q;
  assign carregando   = carregando_q;
  assign erro_timeout = err_q;
  assign db_estado    = db_estado_q;

  // The address space must hold a whole frame
  addr_fits_frame: assert property (@(posedge clock) ADDR_OK);

endmodule

// File: tb/tb_rx_pixel_loader.sv
// Scoreboard bench for rx_pixel_loader with a small 4x2 frame and a 50-cycle timeout.
module tb_rx_pixel_loader;

  localparam int unsigned IMG_W       = 4;
  localparam int unsigned IMG_H       = 2;
  localparam int unsigned ADDR_W      = 15;
  localparam int unsigned TIMEOUT_CYC = 50;
  localparam int unsigned PIX_N       = IMG_W * IMG_H;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              last;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              byte_valid;
  logic [7:0]        byte_in;
  logic              libera;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              frame_ready;
  logic              carregando;
  logic              erro_timeout;
  logic [1:0]        db_estado;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  rx_pixel_loader #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ADDR_W     (ADDR_W),
    .SYNC_BYTE  (8'hAA),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock       (clk),
    .reset       (rst_n),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .libera      (libera),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .frame_ready (frame_ready),
    .carregando  (carregando),
    .erro_timeout(erro_timeout),
    .db_estado   (db_estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every write pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we === 1'b1) begin
      if (sb.size() == 0) begin
        check("we_unexpected", 32'(we), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(addr), 32'(e.addr));
        check("wr_data", 32'(wdata), 32'(e.data));
        check("wr_frame_ready", 32'(frame_ready), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_pixel(input int idx, input logic [7:0] b);
    exp_t e;
    e.addr = ADDR_W'(idx);
    e.data = b;
    e.last = (idx == PIX_N - 1);
    sb.push_back(e);
    send_byte(b);
  endtask

  task automatic load_frame(input logic [7:0] base);
    send_byte(8'hAA);
    for (int i = 0; i < PIX_N; i++) send_pixel(i, base + 8'(i));
  endtask

  task automatic finish_frame(input string tag);
    idle_cycles(2);
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    check({tag, "_ready"}, 32'(frame_ready), 32'd1);
    check({tag, "_state_ready"}, 32'(db_estado), 32'd2);
    libera = 1'b1;
    tick();
    libera = 1'b0;
    check({tag, "_rel_state"}, 32'(db_estado), 32'd0);
    check({tag, "_rel_ready"}, 32'(frame_ready), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_ready"}, 32'(frame_ready), 32'd0);
    check({tag, "_load"}, 32'(carregando), 32'd0);
    check({tag, "_err"}, 32'(erro_timeout), 32'd0);
    check({tag, "_state"}, 32'(db_estado), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1 [PIX_N];
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    libera     = 1'b0;
    f1 = '{8'h10, 8'hAA, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    idle_cycles(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    // 1: basic frame, sync value inside the frame is plain data
    send_byte(8'hAA);
    check("t1_loading", 32'(carregando), 32'd1);
    check("t1_state_load", 32'(db_estado), 32'd1);
    for (int i = 0; i < PIX_N; i++) send_pixel(i, f1[i]);
    idle_cycles(1);
    check("t1_hold_addr", 32'(addr), 32'd7);
    check("t1_hold_wdata", 32'(wdata), 32'h17);
    check("t1_hold_we", 32'(we), 32'd0);
    finish_frame("t1");

    // 2: non-sync bytes in IDLE are dropped
    send_byte(8'h33);
    send_byte(8'h44);
    idle_cycles(1);
    check("t2_state_idle", 32'(db_estado), 32'd0);
    load_frame(8'h50);
    finish_frame("t2");

    // 3: timeout after 50 idle cycles, error clears on next sync
    send_byte(8'hAA);
    for (int i = 0; i < 3; i++) send_pixel(i, 8'h60 + 8'(i));
    idle_cycles(TIMEOUT_CYC - 1);
    check("t3_still_load", 32'(carregando), 32'd1);
    check("t3_no_err_yet", 32'(erro_timeout), 32'd0);
    idle_cycles(1);
    check("t3_err", 32'(erro_timeout), 32'd1);
    check("t3_state_idle", 32'(db_estado), 32'd0);
    check("t3_not_load", 32'(carregando), 32'd0);
    idle_cycles(3);
    check("t3_drain", 32'(sb.size()), 32'd0);
    send_byte(8'hAA);
    check("t3_err_clear", 32'(erro_timeout), 32'd0);
    for (int i = 0; i < PIX_N; i++) send_pixel(i, 8'h70 + 8'(i));
    finish_frame("t3");

    // 4: bytes ignored in READY; release with simultaneous sync is not a sync
    load_frame(8'h80);
    idle_cycles(1);
    send_byte(8'hAA);
    for (int i = 0; i < PIX_N; i++) send_byte(8'h90 + 8'(i));
    check("t4_ready_held", 32'(frame_ready), 32'd1);
    libera     = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'hAA;
    tick();
    libera     = 1'b0;
    byte_valid = 1'b0;
    check("t4_rel_idle", 32'(db_estado), 32'd0);
    check("t4_rel_ready", 32'(frame_ready), 32'd0);
    idle_cycles(1);
    check("t4_no_sync", 32'(db_estado), 32'd0);
    load_frame(8'hA0);
    finish_frame("t4");

    // 5: reset mid-load, next frame restarts at address 0
    send_byte(8'hAA);
    for (int i = 0; i < 5; i++) send_pixel(i, 8'hB0 + 8'(i));
    idle_cycles(1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_rst");
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    check("t5_drain", 32'(sb.size()), 32'd0);
    load_frame(8'hC0);
    finish_frame("t5");

    // 6: byte on the timer's terminal cycle is accepted
    send_byte(8'hAA);
    for (int i = 0; i < 2; i++) send_pixel(i, 8'hD0 + 8'(i));
    idle_cycles(TIMEOUT_CYC - 1);
    send_pixel(2, 8'hD2);
    check("t6_no_err", 32'(erro_timeout), 32'd0);
    check("t6_still_load", 32'(carregando), 32'd1);
    for (int i = 3; i < PIX_N; i++) send_pixel(i, 8'hD0 + 8'(i));
    check("t6_err_final", 32'(erro_timeout), 32'd0);
    finish_frame("t6");

    idle_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
